// File: rtl/scanner_pkg.sv
// Shared encodings for the scanner front end: channel FSM states, command bit
// indices and the scanner/comm state encodings used downstream.
package scanner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } chan_state_e;

    localparam int unsigned CMD_WAKE     = 0;
    localparam int unsigned CMD_TRANSFER = 1;
    localparam int unsigned CMD_SCAN     = 2;
    localparam int unsigned CMD_W        = 3;

    // Bit layout of the userInput bus as seen by the scanner
    typedef struct packed {
        logic scan;
        logic transfer;
        logic wake;
    } user_cmd_t;

    typedef enum logic [1:0] {
        SCN_SLEEP    = 2'd0,
        SCN_IDLE     = 2'd1,
        SCN_SCANNING = 2'd2,
        SCN_TRANSFER = 2'd3
    } scanner_state_e;

    typedef enum logic [1:0] {
        COMM_IDLE     = 2'd0,
        COMM_SEND     = 2'd1,
        COMM_WAIT_ACK = 2'd2,
        COMM_DONE     = 2'd3
    } comm_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, saturating debounce counter and
// press/release FSM. Optional auto-repeat when SCANNER_AUTO_REPEAT_EN is defined.
module debounce_channel
    import scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
`ifdef SCANNER_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = 16
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic held_o,
    output logic accept_c_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef SCANNER_AUTO_REPEAT_EN
    localparam int unsigned      RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_d;
`endif

    logic [1:0]       sync_q;
    chan_state_e      state_q;
    chan_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             held_q;
    logic             held_d;
    logic             level_c;
    logic             accept_c;

    // Flops hold the raw active-low level; reset value 1 means released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign level_c   = ~sync_q[1];
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            held_q  <= 1'b0;
`ifdef SCANNER_AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
`ifdef SCANNER_AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    // The sample that moves a channel into a wait state counts as the first
    // stable sample, so acceptance happens when the incremented count hits the last.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        accept_c = 1'b0;
`ifdef SCANNER_AUTO_REPEAT_EN
        rpt_d    = '0;
`endif
        case (state_q)
            RELEASED: begin
                if (level_c) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!level_c) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_inc_c == CNT_LAST) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    held_d   = 1'b1;
                    accept_c = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            PRESSED: begin
                if (!level_c) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef SCANNER_AUTO_REPEAT_EN
                else if (rpt_q == RPT_LAST) begin
                    accept_c = 1'b1;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (level_c) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_inc_c == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign held_o     = held_q;
    assign accept_c_o = accept_c;

endmodule

// File: rtl/scanner_input_conditioner.sv
// Button front end for the scanner: per-channel debounce plus a fixed-priority
// one-pulse-per-cycle arbiter. Auto-repeat compiled in with SCANNER_AUTO_REPEAT_EN.
module scanner_input_conditioner
    import scanner_pkg::*;
#(
    parameter int unsigned N_INPUTS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] key_n,
    output logic [N_INPUTS-1:0] userInput,
    output logic [N_INPUTS-1:0] held,
    output logic                busy
);

    // Elaboration-time parameter legality
    if (N_INPUTS < 1) begin : g_bad_inputs
        $error("scanner_input_conditioner: N_INPUTS must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("scanner_input_conditioner: DEBOUNCE_CYCLES must be 2..255");
    end
    if (CNT_W < 32 && 64'(DEBOUNCE_CYCLES - 1) >= (64'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("scanner_input_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("scanner_input_conditioner: REPEAT_CYCLES must be at least 1");
    end

    logic [N_INPUTS-1:0] accept_c;
    logic [N_INPUTS-1:0] held_c;
    logic [N_INPUTS-1:0] pending_q;
    logic [N_INPUTS-1:0] pending_d;
    logic [N_INPUTS-1:0] grant_c;
    logic [N_INPUTS-1:0] remain_c;
    logic [N_INPUTS-1:0] user_input_q;
    logic                busy_q;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
`ifdef SCANNER_AUTO_REPEAT_EN
            ,
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk        (clk),
            .rst_n      (reset),
            .key_n_i    (key_n[i]),
            .held_o     (held_c[i]),
            .accept_c_o (accept_c[i])
        );
    end

    // Lowest-index pending bit wins; x & -x isolates it
    assign grant_c   = pending_q & (~pending_q + N_INPUTS'(1));
    assign remain_c  = pending_q & ~grant_c;
    assign pending_d = remain_c | accept_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q    <= '0;
            user_input_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            user_input_q <= grant_c;
            busy_q       <= |remain_c;
        end
    end

    assign userInput = user_input_q;
    assign held      = held_c;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scanner_input_conditioner.sv
// Directed bench for scanner_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_scanner_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] key_n;
    logic [2:0] userInput;
    logic [2:0] held;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p_before = 0;

    always #5 clk = ~clk;

    scanner_input_conditioner #(
        .N_INPUTS        (3),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .userInput (userInput),
        .held      (held),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n edges after an input change; p1/p2 are edges carrying pulses v1/v2,
    // held switches from h_pre to h_post at edge h_edge, busy is high after b_edge only.
    task automatic window(input string tag, input int n,
                          input int p1, input logic [2:0] v1,
                          input int p2, input logic [2:0] v2,
                          input int h_edge, input logic [2:0] h_pre, input logic [2:0] h_post,
                          input int b_edge);
        logic [2:0] exp_u;
        for (int e = 1; e <= n; e++) begin
            tick();
            exp_u = (e == p1) ? v1 : ((e == p2) ? v2 : 3'b000);
            chk($sformatf("%s.userInput@%0d", tag, e), 32'(userInput), 32'(exp_u));
            chk($sformatf("%s.held@%0d", tag, e), 32'(held), 32'((e >= h_edge) ? h_post : h_pre));
            chk($sformatf("%s.busy@%0d", tag, e), 32'(busy), 32'(e == b_edge));
            if (userInput != 3'b000) pulses++;
        end
    endtask

    initial begin
        // Reset held with all buttons pressed: nothing may leak out
        reset = 1'b0;
        key_n = 3'b000;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst.userInput", 32'(userInput), 32'h0);
            chk("rst.held", 32'(held), 32'h0);
            chk("rst.busy", 32'(busy), 32'h0);
        end
        @(negedge clk);
        key_n = 3'b111;
        reset = 1'b1;
        window("idle", 6, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);

        // Single press on key 2: held from edge 6, pulse at edge 7 only
        key_n = 3'b011;
        window("single", 10, 7, 3'b100, 0, 3'b000, 6, 3'b000, 3'b100, 0);
        key_n = 3'b111;
        window("single_rel", 10, 0, 3'b000, 0, 3'b000, 6, 3'b100, 3'b000, 0);

        // Three-sample glitch on key 0: no pulse, no held change
        key_n = 3'b110;
        window("glitch_a", 3, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);
        key_n = 3'b111;
        window("glitch_b", 9, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);

        // Bounce on key 1: low 2, high 1, then held low; pulse 7 edges after the final fall
        p_before = pulses;
        key_n = 3'b101;
        window("bounce_a", 2, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);
        key_n = 3'b111;
        window("bounce_b", 1, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);
        key_n = 3'b101;
        window("bounce_c", 12, 7, 3'b010, 0, 3'b000, 6, 3'b000, 3'b010, 0);
        chk("bounce.pulse_count", 32'(pulses - p_before), 32'd1);
        key_n = 3'b111;
        window("bounce_rel", 10, 0, 3'b000, 0, 3'b000, 6, 3'b010, 3'b000, 0);

        // Keys 0 and 2 together: wake at edge 7, scan at edge 8, busy after edge 7
        key_n = 3'b010;
        window("simul", 10, 7, 3'b001, 8, 3'b100, 6, 3'b000, 3'b101, 7);
        key_n = 3'b111;
        window("simul_rel", 10, 0, 3'b000, 0, 3'b000, 6, 3'b101, 3'b000, 0);

        // Press, release, re-press key 0: two pulses, held falls then rises
        p_before = pulses;
        key_n = 3'b110;
        window("rep_p1", 10, 7, 3'b001, 0, 3'b000, 6, 3'b000, 3'b001, 0);
        key_n = 3'b111;
        window("rep_rel", 10, 0, 3'b000, 0, 3'b000, 6, 3'b001, 3'b000, 0);
        key_n = 3'b110;
        window("rep_p2", 10, 7, 3'b001, 0, 3'b000, 6, 3'b000, 3'b001, 0);
        chk("repress.pulse_count", 32'(pulses - p_before), 32'd2);
        key_n = 3'b111;
        window("rep_rel2", 10, 0, 3'b000, 0, 3'b000, 6, 3'b001, 3'b000, 0);

        // Reset lands on edge 5 of a key 2 press; fresh debounce after release
        key_n = 3'b011;
        window("mr_pre", 4, 0, 3'b000, 0, 3'b000, 99, 3'b000, 3'b000, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_assert.userInput", 32'(userInput), 32'h0);
        chk("mr_assert.held", 32'(held), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mr_hold.userInput", 32'(userInput), 32'h0);
            chk("mr_hold.held", 32'(held), 32'h0);
            chk("mr_hold.busy", 32'(busy), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        window("mr_post", 10, 7, 3'b100, 0, 3'b000, 6, 3'b000, 3'b100, 0);
        key_n = 3'b111;
        window("mr_rel", 10, 0, 3'b000, 0, 3'b000, 6, 3'b100, 3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
